// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory responder slice.
package dmem_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int DEPTH_LOG2_DEF = 12;
    localparam int LAT_DEF        = 2;
    // LAT is limited to 1..15, so the WAIT counter never needs more than 4 bits.
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-port bus between the EX/MEM stage (master) and the responder (slave).
// When DMEM_RANGE_CHK_EN is defined the bus also carries the err flag.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wrt_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              busy;
`ifdef DMEM_RANGE_CHK_EN
    logic              err;

    modport master (output addr, re, we, wrt_data, input rd_data, rd_vld, busy, err);
    modport slave  (input addr, re, we, wrt_data, output rd_data, rd_vld, busy, err);
`else
    modport master (output addr, re, we, wrt_data, input rd_data, rd_vld, busy);
    modport slave  (input addr, re, we, wrt_data, output rd_data, rd_vld, busy);
`endif
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM; the registered read port doubles as the
// responder's rd_data, so it is the only part of the array that is reset.
module dmem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Writes leave rdata untouched so the last load stays visible to the CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one access at a time, LAT WAIT cycles,
// stalls the CPU via busy. Optional out-of-range detection: DMEM_RANGE_CHK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LAT        = LAT_DEF
) (
    input logic              clk,
    input logic              rst_n,
    dmem_responder_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    op_e                     op_q, op_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    oor_q, oor_d;
    logic                    oor_req;
    logic                    req;
    logic                    mem_en;
    logic                    busy;
    logic                    rd_vld;
    logic                    err;

    assign req = bus.re | bus.we;

`ifdef DMEM_RANGE_CHK_EN
    assign oor_req = |bus.addr[ADDR_W-1:DEPTH_LOG2];
    assign bus.err = err;
`else
    // Upper address bits alias onto the array; they are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2];
    assign oor_req        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        oor_d   = oor_q;
        mem_en  = 1'b0;
        busy    = 1'b0;
        rd_vld  = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = req;
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    op_d    = bus.we ? OP_WR : OP_RD;
                    addr_d  = bus.addr[DEPTH_LOG2-1:0];
                    data_d  = bus.wrt_data;
                    oor_d   = oor_req;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    mem_en  = !oor_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // The request still on the bus here is the one just served.
                state_d = IDLE;
                rd_vld  = (op_q == OP_RD) && !oor_q;
                err     = oor_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            data_q  <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            oor_q   <= oor_d;
        end
    end

    assign bus.busy   = busy;
    assign bus.rd_vld = rd_vld;

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_en),
        .we    (op_q == OP_WR),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (bus.rd_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT 2, 1, 15) sharing one CPU-side
// driver; directed table, reset-abort sequence and randomized ops vs a model.
module tb_dmem_responder;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int LAT_C = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic [15:0] addr, wdata;
    logic        re, we;
    logic        busy_s, vld_s;
    logic [15:0] rd_s;
`ifdef DMEM_RANGE_CHK_EN
    logic        err_s;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) if0 ();
    dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) if1 ();
    dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) if2 ();

    assign if0.addr = addr;  assign if0.wrt_data = wdata;
    assign if1.addr = addr;  assign if1.wrt_data = wdata;
    assign if2.addr = addr;  assign if2.wrt_data = wdata;
    assign if0.re = re && (sel == 0);  assign if0.we = we && (sel == 0);
    assign if1.re = re && (sel == 1);  assign if1.we = we && (sel == 1);
    assign if2.re = re && (sel == 2);  assign if2.we = we && (sel == 2);

    dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LAT(LAT_A)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LAT(LAT_B)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LAT(LAT_C)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always_comb begin
        busy_s = if0.busy;  vld_s = if0.rd_vld;  rd_s = if0.rd_data;
`ifdef DMEM_RANGE_CHK_EN
        err_s = if0.err;
`endif
        if (sel == 1) begin
            busy_s = if1.busy;  vld_s = if1.rd_vld;  rd_s = if1.rd_data;
`ifdef DMEM_RANGE_CHK_EN
            err_s = if1.err;
`endif
        end else if (sel == 2) begin
            busy_s = if2.busy;  vld_s = if2.rd_vld;  rd_s = if2.rd_data;
`ifdef DMEM_RANGE_CHK_EN
            err_s = if2.err;
`endif
        end
    end

    initial begin
        if (!(LAT_A >= 1 && LAT_A <= 15 && LAT_B >= 1 && LAT_B <= 15 && LAT_C >= 1 && LAT_C <= 15))
            $fatal(1, "LAT parameter outside 1..15");
    end

    // Behavioural reference: word array per instance plus the last loaded value.
    int          lat_of [3] = '{LAT_A, LAT_B, LAT_C};
    logic [15:0] mdl [3][4096];
    logic [15:0] last_rd [3] = '{16'h0, 16'h0, 16'h0};

    task automatic predict(input int d, input logic w, input logic r, input logic [15:0] a,
                           input logic [15:0] wd, output int ev, output logic [15:0] erd,
                           output logic ee);
        logic oor;
        oor = 1'b0;
`ifdef DMEM_RANGE_CHK_EN
        oor = (a >> 12) != 0;
`endif
        ev = 0;
        ee = oor;
        if (!oor) begin
            if (w) mdl[d][a % 4096] = wd;
            else if (r) begin
                last_rd[d] = mdl[d][a % 4096];
                ev = 1;
            end
        end
        erd = last_rd[d];
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One CPU access: hold the request until DONE, drop it on the DONE edge,
    // then observe one further cycle to catch a spurious re-acceptance.
    task automatic do_access(input int d, input logic w, input logic r, input logic [15:0] a,
                             input logic [15:0] wd, output int bcyc, output int nvld,
                             output logic [15:0] rdat, output logic er, output logic pb,
                             output logic to);
        bit done;
        sel = d;
        @(posedge clk); #1;
        addr = a; wdata = wd; we = w; re = r;
        bcyc = 0; nvld = 0; done = 0; rdat = '0; er = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (vld_s) nvld++;
            if (busy_s) bcyc++;
            else begin
                rdat = rd_s;
`ifdef DMEM_RANGE_CHK_EN
                er = err_s;
`endif
                done = 1;
                break;
            end
        end
        to = !done;
        @(posedge clk); #1;
        re = 1'b0; we = 1'b0;
        @(negedge clk);
        pb = busy_s;
        if (vld_s) nvld++;
    endtask

    task automatic run_checked(input int d, input logic w, input logic r, input logic [15:0] a,
                               input logic [15:0] wd, input string nm);
        int bc, nv, ev;
        logic [15:0] rdat, erd;
        logic er, pb, to, ee;
        predict(d, w, r, a, wd, ev, erd, ee);
        do_access(d, w, r, a, wd, bc, nv, rdat, er, pb, to);
        check({nm, ".timeout"}, to, 0);
        check({nm, ".busy_cycles"}, bc, lat_of[d] + 1);
        check({nm, ".vld_pulses"}, nv, ev);
        check({nm, ".rd_data"}, rdat, erd);
        check({nm, ".busy_after"}, pb, 0);
`ifdef DMEM_RANGE_CHK_EN
        check({nm, ".err"}, er, ee);
`endif
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] a;
        logic [15:0] wd;
        int          evld;
        logic [15:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, nv, ev;
        logic [15:0] rdat, erd;
        logic er, pb, to, ee;
        logic [11:0] pool [8];

        tbl[0] = '{1'b1, 1'b0, 16'h0010, 16'h1234, 0, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 1, 16'h1234, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 0, 16'h1234, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 1, 16'hBEEF, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'h0030, 16'h1111, 0, 16'hBEEF, 1'b0};
`ifdef DMEM_RANGE_CHK_EN
        tbl[5] = '{1'b1, 1'b0, 16'h1030, 16'hAAAA, 0, 16'hBEEF, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 16'h0030, 16'h0000, 1, 16'h1111, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 16'h1030, 16'h0000, 0, 16'h1111, 1'b1};
`else
        tbl[5] = '{1'b1, 1'b0, 16'h1030, 16'hAAAA, 0, 16'hBEEF, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 16'h0030, 16'h0000, 1, 16'hAAAA, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 16'h1030, 16'h0000, 1, 16'hAAAA, 1'b0};
`endif

        sel = 0; addr = '0; wdata = '0; re = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", busy_s, 0);
        check("reset.rd_vld", vld_s, 0);
        check("reset.rd_data", rd_s, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            predict(0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd, ev, erd, ee);
            do_access(0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].wd, bc, nv, rdat, er, pb, to);
            check($sformatf("tbl%0d.timeout", i), to, 0);
            check($sformatf("tbl%0d.busy_cycles", i), bc, LAT_A + 1);
            check($sformatf("tbl%0d.vld_pulses", i), nv, tbl[i].evld);
            check($sformatf("tbl%0d.rd_data", i), rdat, tbl[i].erd);
            check($sformatf("tbl%0d.busy_after", i), pb, 0);
`ifdef DMEM_RANGE_CHK_EN
            check($sformatf("tbl%0d.err", i), er, tbl[i].eerr);
`endif
        end

        // Reset in the first WAIT cycle must abort the pending write.
        run_checked(0, 1'b1, 1'b0, 16'h0030, 16'h0000, "rst.pre_write");
        sel = 0;
        @(posedge clk); #1;
        addr = 16'h0030; wdata = 16'h5555; we = 1'b1;
        @(posedge clk); #1;
        check("rst.busy_in_wait", busy_s, 1);
        rst_n = 1'b0; we = 1'b0;
        #1;
        check("rst.busy_drop", busy_s, 0);
        check("rst.rd_vld_drop", vld_s, 0);
        check("rst.rd_data_clr", rd_s, 0);
`ifdef DMEM_RANGE_CHK_EN
        check("rst.err_clr", err_s, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) last_rd[d] = 16'h0000;
        run_checked(0, 1'b0, 1'b1, 16'h0030, 16'h0000, "rst.read_back");

        // Latency extremes.
        run_checked(1, 1'b1, 1'b0, 16'h0005, 16'h0F0F, "lat1.wr");
        run_checked(1, 1'b0, 1'b1, 16'h0005, 16'h0000, "lat1.rd");
        run_checked(2, 1'b1, 1'b0, 16'h0777, 16'h7E7E, "lat15.wr");
        run_checked(2, 1'b0, 1'b1, 16'h0777, 16'h0000, "lat15.rd");

        // Randomized traffic over a small address pool with occasional high bits.
        for (int j = 0; j < 8; j++) begin
            pool[j] = 12'($urandom_range(0, 4095));
            run_checked(0, 1'b1, 1'b0, {4'h0, pool[j]}, 16'($urandom), $sformatf("rnd_init%0d", j));
        end
        for (int j = 0; j < 40; j++) begin
            int k;
            logic [3:0] hi;
            logic w, r;
            k  = $urandom_range(0, 3);
            hi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            w  = (k == 0) || (k == 2);
            r  = (k != 0);
            run_checked(0, w, r, {hi, pool[$urandom_range(0, 7)]}, 16'($urandom),
                        $sformatf("rnd%0d", j));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
